// File: rtl/mem_link_master.sv
// Bus master for a DEPTH-entry byte memory on a shared 8-bit tri-state link.
// Converts host write/read bursts into the link's FF / 00 / data-byte command protocol.
module mem_link_master #(
    parameter int         DEPTH  = 5,
    parameter logic [7:0] STROBE = 8'h5A
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       wr_req_i,
    input  logic       rd_req_i,
    output logic       req_ready_o,
    input  logic [7:0] wr_data_i,
    input  logic       wr_valid_i,
    output logic       wr_ready_o,
    output logic [7:0] rd_data_o,
    output logic       rd_valid_o,
    inout  wire  [7:0] data_io,
    output logic       tx_oe_o,
    output logic [2:0] ptr_o,
    output logic       sat_o,
    output logic       sync_err_o
);

    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_W_CMD    = 3'd1;
    localparam logic [2:0] S_W_DATA   = 3'd2;
    localparam logic [2:0] S_W_END    = 3'd3;
    localparam logic [2:0] S_R_STROBE = 3'd4;
    localparam logic [2:0] S_R_SAMPLE = 3'd5;

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [7:0]    link_q;
    logic          oe_q;
    logic          wr_fire;

    // The link is driven by exactly one side at all times: us when oe_q is low.
    assign data_io     = oe_q ? 8'bz : link_q;
    assign tx_oe_o     = oe_q;
    assign req_ready_o = (state == S_IDLE) && !rst_i;
    assign wr_ready_o  = ((state == S_W_CMD) || (state == S_W_DATA)) && (cnt < CW'(DEPTH));
    assign wr_fire     = wr_valid_i && wr_ready_o;

    // Payload bytes must never alias the FF/00 command bytes.
    function automatic logic [7:0] remap(input logic [7:0] b);
        if (b == 8'h00) return 8'h01;
        if (b == 8'hFF) return 8'hFE;
        return b;
    endfunction

    function automatic logic [2:0] ptr_inc(input logic [2:0] p);
        return (p == 3'(DEPTH - 1)) ? 3'd0 : p + 3'd1;
    endfunction

    // NOTE: every register here is assigned with <= so all of them update from pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= S_IDLE;
            cnt        <= '0;
            link_q     <= 8'h00;
            oe_q       <= 1'b0;
            ptr_o      <= 3'd0;
            sat_o      <= 1'b0;
            sync_err_o <= 1'b0;
            rd_data_o  <= 8'h00;
            rd_valid_o <= 1'b0;
        end else begin
            rd_valid_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    link_q <= 8'h00;
                    oe_q   <= 1'b0;
                    cnt    <= '0;
                    if (wr_req_i) begin
                        state  <= S_W_CMD;
                        link_q <= 8'hFF;
                    end else if (rd_req_i) begin
                        state  <= S_R_STROBE;
                        link_q <= STROBE;
                        ptr_o  <= ptr_inc(ptr_o);
                    end
                end
                S_W_CMD, S_W_DATA: begin
                    if (wr_fire) begin
                        link_q <= remap(wr_data_i);
                        cnt    <= cnt + 1'b1;
                        ptr_o  <= ptr_inc(ptr_o);
                        if ((wr_data_i == 8'h00) || (wr_data_i == 8'hFF)) sat_o <= 1'b1;
                        state  <= (cnt == CW'(DEPTH - 1)) ? S_W_END : S_W_DATA;
                    end else begin
                        // Re-sending FF keeps write mode without advancing the memory address.
                        link_q <= 8'hFF;
                        state  <= S_W_DATA;
                    end
                end
                S_W_END: begin
                    link_q <= 8'h00;
                    state  <= S_IDLE;
                end
                S_R_STROBE: begin
                    oe_q  <= 1'b1;
                    cnt   <= '0;
                    state <= S_R_SAMPLE;
                end
                S_R_SAMPLE: begin
                    rd_data_o  <= data_io;
                    rd_valid_o <= 1'b1;
                    cnt        <= cnt + 1'b1;
                    if (data_io == 8'h00) sync_err_o <= 1'b1;
                    else if (data_io != 8'hFF) ptr_o <= ptr_inc(ptr_o);
                    if (cnt == CW'(DEPTH - 1)) begin
                        // Take the link back on the same edge the memory releases it.
                        oe_q   <= 1'b0;
                        link_q <= 8'h00;
                        state  <= S_IDLE;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    link_q <= 8'h00;
                    oe_q   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_link_master.md
# mem_link_master

Bus master for the 5-entry byte memory on the shared 8-bit tri-state link. It turns a request/stream interface from the host side into the link's command-byte protocol:
- 0xFF enters write mode.
- 0x00 leaves write mode.
- Any other byte is a data/strobe byte that advances the memory's internal address.

It owns the link direction (`tx_oe_o`) and keeps a mirror of the memory's address pointer.

## Interface
Parameters:
- `DEPTH`, 5: memory entries per burst; equals the memory size.
- `STROBE`, 8'h5A: read-strobe byte; must not be 8'h00 or 8'hFF.

Ports:
- `clk_i` in 1: clock; memory shares it.
- `rst_i` in 1: reset, synchronous, active-high; memory shares it.
- `wr_req_i` in 1: start a write burst.
- `rd_req_i` in 1: start a read burst.
- `req_ready_o` out 1: idle; requests are accepted at an edge where this is high.
- `wr_data_i` in 8: payload byte.
- `wr_valid_i` in 1: payload valid.
- `wr_ready_o` out 1: payload byte accepted when `wr_valid_i` and `wr_ready_o` are both high.
- `rd_data_o` out 8: read-back byte.
- `rd_valid_o` out 1: one-cycle pulse per read-back byte.
- `data_io` inout 8: shared link.
- `tx_oe_o` out 1: memory drives the link when high.
- `ptr_o` out 3: mirrored memory address, 0..`DEPTH`-1.
- `sat_o` out 1: sticky; a payload byte was remapped.
- `sync_err_o` out 1: sticky; 8'h00 sampled during a read.

## Operation
- **Link ownership rules**
  - The block drives `data_io` exactly when `tx_oe_o` is 0.
  - The link is never undriven.
  - Link byte and `tx_oe_o` are registered.
- **Idle drive:** 8'h00 in IDLE; harmless in memory read mode.
- **States:** IDLE, W_CMD, W_DATA, W_END, R_STROBE, R_SAMPLE.
- **Request arbitration**
  - In IDLE, `wr_req_i` has priority over `rd_req_i`.
  - Requests are ignored outside IDLE.
  - A losing `rd_req_i` must be held by the host.
- **Write path**
  - IDLE goes to W_CMD, which drives 8'hFF.
  - W_DATA drives each accepted byte.
  - On cycles with no accepted byte, W_DATA drives 8'hFF; this holds write mode and does not advance the address.
  - After `DEPTH` bytes, the FSM moves to W_END, which drives 8'h00 for one cycle, then returns to IDLE.
  - `wr_ready_o` is high in W_CMD/W_DATA while the accepted count is below `DEPTH`.
- **Payload remap:** 8'h00 is sent as 8'h01 and 8'hFF as 8'hFE. Each remap sets `sat_o`.
- **Pointer mirror:** `ptr_o` increments mod `DEPTH` for each data byte placed on the link. After a full write burst, `ptr_o` is unchanged.
- **Read path**
  - R_STROBE drives `STROBE` for one cycle; memory loads entry `ptr` and increments.
  - R_SAMPLE lasts `DEPTH` cycles. In it, `tx_oe_o`=1 and the link is released, and the block samples `data_io` each cycle.
  - The memory self-advances on each sampled non-00/FF byte.
  - Returned order: entries `ptr`, `ptr`+1, ... mod `DEPTH`.
  - After a read burst, `ptr_o` = `ptr`+1 mod `DEPTH`.
- **Read sync error**
  - A sampled 8'h00 sets `sync_err_o`.
  - All `DEPTH` samples are still delivered.
  - `ptr_o` is no longer guaranteed; only reset clears the error.
- **Reset**, including mid-burst, applied on the next edge:
  - State goes to IDLE; link drives 8'h00; `tx_oe_o`=0.
  - `wr_ready_o`=0, `rd_valid_o`=0, `rd_data_o`=8'h00.
  - `ptr_o`=0, `sat_o`=0, `sync_err_o`=0.
  - `req_ready_o` is 0 while `rst_i` is high.
  - The memory resets on the same edge, so the pointer mirror stays consistent.

## Timing
- **Write**, request accepted at edge E0:
  - Link = FF during cycle E0+1.
  - Byte accepted at edge Ek appears on the link during cycle Ek+1.
  - With back-to-back payload, the link sequence is FF, b0..b4, 00. `req_ready_o` returns high 7 cycles after E0.
- **Read**, request accepted at E0:
  - `STROBE` is on the link during cycle E0+1.
  - `tx_oe_o` is high during cycles E0+2..E0+6.
  - `rd_valid_o` is high during cycles E0+3..E0+7.
  - During cycle E0+7 the link is driven with 8'h00 and `tx_oe_o`=0, in the same cycle; there is no float cycle.
- **Turnaround:** `tx_oe_o` falling and the block driving happen on the same edge.
- **Throughput:** bursts can issue back-to-back, one idle cycle minimum between bursts.

## Test plan
- Assert reset for 2 cycles mid-traffic -> all outputs at their reset values; link carries 8'h00; `req_ready_o` goes high on the first cycle after `rst_i` falls.
- Write 11,22,33,44,55 back-to-back, then read -> link sequence FF,11,22,33,44,55,00; `rd_data_o` 11,22,33,44,55 at E0+3..E0+7; `ptr_o` goes 0 -> 1.
- Write with `wr_valid_i` low for 2 cycles between each byte -> link shows FF during the gaps; a subsequent read returns the exact payload.
- Write payload 00,FF,10,20,30 -> link carries 01,FE,10,20,30; `sat_o`=1; read-back returns 01,FE,10,20,30.
- Read immediately after reset (memory all zero) -> first sample 00; `sync_err_o`=1; exactly 5 `rd_valid_o` pulses.
- Raise `wr_req_i` and `rd_req_i` in the same cycle -> write burst runs first, read follows. Separately, reset after 2 payload bytes -> IDLE, `ptr_o`=0, link 8'h00.
